// File: rtl/edabk_transmitter_ctrl_dp.sv
`timescale 1ns/1ps
// UART transmitter: FSM, bit-period counter and shift datapath in one block.
// Frames are start, DATA_WIDTH bits LSB first, optional parity, then 1 or 2 stop bits.
module edabk_transmitter_ctrl_dp #(
  parameter int CLK_DIV     = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = $clog2(CLK_DIV),
  parameter int BIT_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLK_DIV - 1);
  localparam logic [COUNT_WIDTH-1:0] NEAR_COUNT = COUNT_WIDTH'(CLK_DIV - 2);
  localparam logic [BIT_WIDTH-1:0]   LAST_BIT   = BIT_WIDTH'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [COUNT_WIDTH-1:0]  count, count_nxt;
  logic [BIT_WIDTH-1:0]    bit_idx, bit_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
  logic                    parity_bit, parity_en, stop2_q;
  logic                    tx_out_nxt, tx_ready_nxt;
  logic                    accept, wrap, final_stop;

  assign accept     = tx_valid & tx_ready;
  assign wrap       = (count == LAST_COUNT);
  assign final_stop = (state == STOP2) || ((state == STOP1) && !stop2_q);

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (wrap) state_nxt = DATA;
      DATA:    if (wrap && (bit_idx == LAST_BIT)) state_nxt = parity_en ? PARITY : STOP1;
      PARITY:  if (wrap) state_nxt = STOP1;
      STOP1:   if (wrap) state_nxt = stop2_q ? STOP2 : (accept ? START : IDLE);
      STOP2:   if (wrap) state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_out and tx_ready are registered, so they are decoded from the upcoming state
  always_comb begin
    count_nxt = count;
    bit_nxt   = bit_idx;
    shift_nxt = shift_reg;
    if (accept) begin
      count_nxt = '0;
      bit_nxt   = '0;
      shift_nxt = tx_data;
    end else if (state != IDLE) begin
      count_nxt = wrap ? '0 : count + 1'b1;
      if ((state == DATA) && wrap) begin
        shift_nxt = {1'b1, shift_reg[DATA_WIDTH-1:1]};
        bit_nxt   = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
      end
    end

    case (state_nxt)
      START:   tx_out_nxt = 1'b0;
      DATA:    tx_out_nxt = shift_nxt[0];
      PARITY:  tx_out_nxt = parity_bit;
      default: tx_out_nxt = 1'b1;
    endcase

    // Ready is raised one cycle early so it coincides with the frame_done cycle
    tx_ready_nxt = (state_nxt == IDLE) || (final_stop && (count == NEAR_COUNT));
    busy         = (state != IDLE);
    frame_done   = final_stop && wrap;
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '1;
      parity_bit <= 1'b0;
      parity_en  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b0;
    end else begin
      count     <= count_nxt;
      bit_idx   <= bit_nxt;
      shift_reg <= shift_nxt;
      tx_out    <= tx_out_nxt;
      tx_ready  <= tx_ready_nxt;
      if (accept) begin
        parity_bit <= (^tx_data) ^ (parity_mode == 2'b10);
        parity_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        stop2_q    <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_edabk_transmitter_ctrl_dp.sv
`timescale 1ns/1ps
// Self-checking bench: two transmitter instances (8-bit/16x and 5-bit/4x) compared
// cycle by cycle against a frame model built from the bit-sequence rules.
module tb_edabk_transmitter_ctrl_dp;

  logic       bclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid_a, tx_valid_b;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx_ready_a, tx_out_a, busy_a, frame_done_a;
  logic       tx_ready_b, tx_out_b, busy_b, frame_done_b;

  logic       sel_q = 1'b0;
  logic       obs_tx, obs_busy, obs_ready, obs_done;
  int         check_count = 0;
  int         error_count = 0;
  bit         exp_bits[$];

  always #5 bclk = ~bclk;

  edabk_transmitter_ctrl_dp #(.CLK_DIV(16), .DATA_WIDTH(8)) dut_a (
    .bclk(bclk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .parity_mode(parity_mode), .stop2(stop2),
    .tx_out(tx_out_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  edabk_transmitter_ctrl_dp #(.CLK_DIV(4), .DATA_WIDTH(5)) dut_b (
    .bclk(bclk), .reset(reset), .tx_data(tx_data[4:0]), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .parity_mode(parity_mode), .stop2(stop2),
    .tx_out(tx_out_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  assign obs_tx    = sel_q ? tx_out_b     : tx_out_a;
  assign obs_busy  = sel_q ? busy_b       : busy_a;
  assign obs_ready = sel_q ? tx_ready_b   : tx_ready_a;
  assign obs_done  = sel_q ? frame_done_b : frame_done_a;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t, dut=%s)", tag, observed, expected,
               $time, sel_q ? "b" : "a");
    end
  endtask

  // Reference frame as a list of line levels, one entry per serial bit
  task automatic buildFrame(input logic [7:0] data, input logic [1:0] pmode, input logic s2,
                            input int dw);
    bit par;
    par = 1'b0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_bits.push_back(data[i]);
      par ^= data[i];
    end
    if (pmode == 2'b01)      exp_bits.push_back(par);
    else if (pmode == 2'b10) exp_bits.push_back(!par);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Offers one word on the next edge, then scrambles the inputs and checks every cycle.
  // With hold set, tx_valid stays high so the following call chains with no gap.
  task automatic applyStimulus(input logic sel, input logic [7:0] data, input logic [1:0] pmode,
                               input logic s2, input bit hold);
    int dw, div, len;
    dw    = sel ? 5 : 8;
    div   = sel ? 4 : 16;
    sel_q = sel;
    buildFrame(data, pmode, s2, dw);
    len = exp_bits.size() * div;
    tx_data     = data;
    parity_mode = pmode;
    stop2       = s2;
    if (sel) tx_valid_b = 1'b1;
    else     tx_valid_a = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(posedge bclk); #1;
      if (k == 0) begin
        tx_data     = 8'($urandom);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
        if (!hold) begin
          tx_valid_a = 1'b0;
          tx_valid_b = 1'b0;
        end
      end
      checkOutput($sformatf("tx_out k=%0d", k), obs_tx, exp_bits[k / div]);
      checkOutput($sformatf("busy k=%0d", k), obs_busy, 1'b1);
      checkOutput($sformatf("frame_done k=%0d", k), obs_done, k == len - 1);
      checkOutput($sformatf("tx_ready k=%0d", k), obs_ready, k == len - 1);
    end
  endtask

  task automatic checkIdle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge bclk); #1;
      checkOutput("idle tx_out", obs_tx, 1'b1);
      checkOutput("idle busy", obs_busy, 1'b0);
      checkOutput("idle frame_done", obs_done, 1'b0);
      checkOutput("idle tx_ready", obs_ready, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hold;
    reset       = 1'b1;
    tx_data     = '0;
    tx_valid_a  = 1'b0;
    tx_valid_b  = 1'b0;
    parity_mode = 2'b00;
    stop2       = 1'b0;

    // Reset state on both instances
    #23;
    for (int s = 0; s < 2; s++) begin
      sel_q = 1'(s); #1;
      checkOutput("reset tx_out", obs_tx, 1'b1);
      checkOutput("reset busy", obs_busy, 1'b0);
      checkOutput("reset tx_ready", obs_ready, 1'b0);
      checkOutput("reset frame_done", obs_done, 1'b0);
    end
    @(posedge bclk); #1;
    reset = 1'b0;
    @(posedge bclk); #1;
    sel_q = 1'b0; checkOutput("first edge tx_ready", obs_ready, 1'b1);
    sel_q = 1'b1; checkOutput("first edge tx_ready", obs_ready, 1'b1);

    // Long idle with no valid
    sel_q = 1'b0;
    checkIdle(500);

    // Directed frames: plain, parity even/odd, two stop bits back to back
    applyStimulus(1'b0, 8'hA5, 2'b00, 1'b0, 1'b0);
    checkIdle(3);
    applyStimulus(1'b0, 8'h07, 2'b01, 1'b0, 1'b0);
    checkIdle(1);
    applyStimulus(1'b0, 8'h07, 2'b10, 1'b0, 1'b0);
    checkIdle(1);
    applyStimulus(1'b0, 8'h3C, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'hC3, 2'b00, 1'b1, 1'b0);
    checkIdle(2);

    // Abort by reset during data bit 3 of 0xB6 (that bit is 0)
    sel_q       = 1'b0;
    tx_data     = 8'hB6;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    tx_valid_a  = 1'b1;
    @(posedge bclk); #1;
    tx_valid_a = 1'b0;
    repeat (16 * 4 + 5) @(posedge bclk);
    #1;
    checkOutput("abort pre busy", obs_busy, 1'b1);
    checkOutput("abort pre tx_out", obs_tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort tx_out", obs_tx, 1'b1);
    checkOutput("abort busy", obs_busy, 1'b0);
    checkOutput("abort tx_ready", obs_ready, 1'b0);
    checkOutput("abort frame_done", obs_done, 1'b0);
    repeat (3) begin
      @(posedge bclk); #1;
      checkOutput("in reset frame_done", obs_done, 1'b0);
      checkOutput("in reset tx_out", obs_tx, 1'b1);
    end
    reset = 1'b0;
    @(posedge bclk); #1;
    checkOutput("post reset tx_ready", obs_ready, 1'b1);
    checkOutput("post reset busy", obs_busy, 1'b0);
    applyStimulus(1'b0, 8'h55, 2'b00, 1'b0, 1'b0);
    checkIdle(2);

    // Narrow instance, parity code 11 means no parity
    applyStimulus(1'b1, 8'h1F, 2'b11, 1'b0, 1'b0);
    checkIdle(2);

    // Randomized frames, some chained back to back
    for (int i = 0; i < 8; i++) begin
      hold = (i < 7) && ($urandom_range(0, 1) == 1);
      applyStimulus(1'b0, 8'($urandom), 2'($urandom), 1'($urandom), hold);
      if (!hold) checkIdle(2);
    end
    for (int i = 0; i < 6; i++) begin
      hold = (i < 5) && ($urandom_range(0, 1) == 1);
      applyStimulus(1'b1, 8'($urandom), 2'($urandom), 1'($urandom), hold);
      if (!hold) checkIdle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
